// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer: issues the next obstacle type and hitbox width on each spawn request,
// enforces a minimum spawn gap and drives the bird wing-flap frame. Macro OBSTACLE_LFSR_EN
// selects LFSR-based random selection; without it a fixed type rotation is used.
module obstacle_sequencer #(
  parameter int unsigned NUM_TYPES  = 5,
  parameter int unsigned MIN_GAP    = 8,
  parameter int unsigned MAX_REPEAT = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       animateclk,
  input  logic       rst,
  input  logic [1:0] gamestate,
  input  logic       spawn_req,
  output logic       obs_valid,
  output logic [3:0] obstacle_sel,
  output logic [9:0] final_width,
  output logic       bird_frame,
  output logic       req_pending
);

  localparam logic [1:0] GS_RUNNING = 2'b01;
  localparam logic [1:0] GS_DEAD    = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARMED  = 2'b01;
  localparam logic [1:0] ST_GAP    = 2'b10;
  localparam logic [1:0] ST_FROZEN = 2'b11;

  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP);

  if ((NUM_TYPES < 1) || (NUM_TYPES > 5) || (MIN_GAP > 255) ||
      (MAX_REPEAT < 1) || (LFSR_SEED == 16'h0)) begin : g_bad_cfg
    $error("obstacle_sequencer: illegal parameter set");
  end

  // Type index order: 0 Cac1S, 1 Cac2S, 2 Cac1B, 3 Cac2B, 4 Bird
  function automatic logic [3:0] code_of(input logic [2:0] idx);
    case (idx)
      3'd0:    code_of = 4'b0100;
      3'd1:    code_of = 4'b0110;
      3'd2:    code_of = 4'b0101;
      3'd3:    code_of = 4'b0111;
      default: code_of = 4'b1000;
    endcase
  endfunction

  function automatic logic [9:0] width_of(input logic [2:0] idx);
    case (idx)
      3'd0:    width_of = 10'd34;
      3'd1:    width_of = 10'd68;
      3'd2:    width_of = 10'd50;
      3'd3:    width_of = 10'd100;
      default: width_of = 10'd92;
    endcase
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       req_pending_q, req_pending_d;
  logic       obs_valid_q, obs_valid_d;
  logic [3:0] sel_q, sel_d;
  logic [9:0] width_q, width_d;
  logic       bird_q, bird_d;
  logic [2:0] next_idx;
  logic       ticking;
  logic       issue;

  // Actions need both the registered mode and a live Running gamestate, so a
  // Dead/UnBegin input stops everything on the very edge it is first seen.
  assign ticking = (gamestate == GS_RUNNING) &&
                   ((state_q == ST_ARMED) || (state_q == ST_GAP));
  assign issue   = ticking && (state_q == ST_ARMED) && (spawn_req || req_pending_q);

`ifdef OBSTACLE_LFSR_EN
  localparam int unsigned   RW         = $clog2(MAX_REPEAT + 1);
  localparam logic [RW-1:0] REPEAT_LIM = RW'(MAX_REPEAT - 1);
  localparam logic [2:0]    CAND_RST   = 3'(32'(LFSR_SEED[7:0]) % NUM_TYPES);

  logic [15:0]   lfsr_q, lfsr_d;
  logic [2:0]    cand_q, cand_d;
  logic [2:0]    last_q, last_d;
  logic [RW-1:0] repeat_q, repeat_d;
  logic          force_next;

  always_comb begin
    force_next = (NUM_TYPES > 1) && (cand_q == last_q) && (repeat_q == REPEAT_LIM);
    next_idx   = force_next ? 3'((32'(cand_q) + 1) % NUM_TYPES) : cand_q;
  end

  always_comb begin
    lfsr_d   = lfsr_q;
    cand_d   = cand_q;
    last_d   = last_q;
    repeat_d = repeat_q;
    if (ticking) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      cand_d = 3'(32'(lfsr_q[7:0]) % NUM_TYPES);
    end
    if (issue) begin
      last_d = next_idx;
      if (next_idx == last_q) begin
        if (repeat_q != '1) begin
          repeat_d = repeat_q + 1'b1;
        end
      end else begin
        repeat_d = '0;
      end
    end
  end

  // last index starts at Cac2B to agree with the reset-time obstacle_sel
  always_ff @(posedge animateclk or posedge rst) begin
    if (rst) begin
      lfsr_q   <= LFSR_SEED;
      cand_q   <= CAND_RST;
      last_q   <= 3'd3;
      repeat_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      cand_q   <= cand_d;
      last_q   <= last_d;
      repeat_q <= repeat_d;
    end
  end
`else
  // Rotation position 0..4 maps to Cac2B, Cac1B, Bird, Cac2S, Cac1S
  function automatic logic [2:0] rot_to_idx(input logic [2:0] pos);
    case (pos)
      3'd0:    rot_to_idx = 3'd3;
      3'd1:    rot_to_idx = 3'd2;
      3'd2:    rot_to_idx = 3'd4;
      3'd3:    rot_to_idx = 3'd1;
      default: rot_to_idx = 3'd0;
    endcase
  endfunction

  logic [2:0] rot_q, rot_d;
  logic [2:0] rot_next;

  always_comb begin
    rot_next = ((32'(rot_q) + 1) >= NUM_TYPES) ? '0 : rot_q + 3'd1;
    next_idx = rot_to_idx(rot_next);
    rot_d    = rot_q;
    if (issue) begin
      rot_d = rot_next;
    end
  end

  always_ff @(posedge animateclk or posedge rst) begin
    if (rst) begin
      rot_q <= '0;
    end else begin
      rot_q <= rot_d;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    req_pending_d = req_pending_q;
    obs_valid_d   = 1'b0;
    sel_d         = sel_q;
    width_d       = width_q;
    bird_d        = bird_q;
    if (ticking) begin
      bird_d = ~bird_q;
      if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
        gap_cnt_d = gap_cnt_q - 8'd1;
      end
      if ((state_q == ST_GAP) && spawn_req) begin
        req_pending_d = 1'b1;
      end
    end
    if (issue) begin
      obs_valid_d   = 1'b1;
      sel_d         = code_of(next_idx);
      width_d       = width_of(next_idx);
      req_pending_d = 1'b0;
      gap_cnt_d     = GAP_LOAD;
    end
    // ARMED vs GAP follows the counter, so a resume lands in whichever one it held
    case (gamestate)
      GS_DEAD:    state_d = ST_FROZEN;
      GS_RUNNING: state_d = (gap_cnt_d == '0) ? ST_ARMED : ST_GAP;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge animateclk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gap_cnt_q     <= '0;
      req_pending_q <= 1'b0;
      obs_valid_q   <= 1'b0;
      sel_q         <= 4'b0111;
      width_q       <= 10'd100;
      bird_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      req_pending_q <= req_pending_d;
      obs_valid_q   <= obs_valid_d;
      sel_q         <= sel_d;
      width_q       <= width_d;
      bird_q        <= bird_d;
    end
  end

  assign obs_valid    = obs_valid_q;
  assign obstacle_sel = sel_q;
  assign final_width  = width_q;
  assign bird_frame   = bird_q;
  assign req_pending  = req_pending_q;

  a_gap_has_count: assert property (@(posedge animateclk) disable iff (rst)
    (state_q == ST_GAP) |-> (gap_cnt_q != '0));
  a_armed_no_count: assert property (@(posedge animateclk) disable iff (rst)
    (state_q == ST_ARMED) |-> (gap_cnt_q == '0));
  a_issue_clears_pending: assert property (@(posedge animateclk) disable iff (rst)
    obs_valid_q |-> !req_pending_q);

endmodule

// File: tb/tb_obstacle_sequencer.sv
// Directed bench for obstacle_sequencer: reset, issue latency, gap/pending handling,
// freeze/resume, rotation (or LFSR repeat rule when OBSTACLE_LFSR_EN is set), MIN_GAP=0.
module tb_obstacle_sequencer;

  logic       animateclk = 1'b0;
  logic       rst        = 1'b0;
  logic [1:0] gamestate  = 2'b00;
  logic       spawn_req  = 1'b0;
  logic       spawn_req0 = 1'b0;

  logic       obs_valid, bird_frame, req_pending;
  logic [3:0] obstacle_sel;
  logic [9:0] final_width;
  logic       obs_valid0, bird_frame0, req_pending0;
  logic [3:0] obstacle_sel0;
  logic [9:0] final_width0;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifndef OBSTACLE_LFSR_EN
  logic [3:0] rot_sel [0:4] = '{4'b0101, 4'b1000, 4'b0110, 4'b0100, 4'b0111};
`endif

  always #5 animateclk = ~animateclk;

  obstacle_sequencer #(.NUM_TYPES(5), .MIN_GAP(8), .MAX_REPEAT(2), .LFSR_SEED(16'hACE1)) u_dut (
    .animateclk  (animateclk),
    .rst         (rst),
    .gamestate   (gamestate),
    .spawn_req   (spawn_req),
    .obs_valid   (obs_valid),
    .obstacle_sel(obstacle_sel),
    .final_width (final_width),
    .bird_frame  (bird_frame),
    .req_pending (req_pending)
  );

  obstacle_sequencer #(.NUM_TYPES(2), .MIN_GAP(0), .MAX_REPEAT(2), .LFSR_SEED(16'hACE1)) u_dut0 (
    .animateclk  (animateclk),
    .rst         (rst),
    .gamestate   (gamestate),
    .spawn_req   (spawn_req0),
    .obs_valid   (obs_valid0),
    .obstacle_sel(obstacle_sel0),
    .final_width (final_width0),
    .bird_frame  (bird_frame0),
    .req_pending (req_pending0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge animateclk);
    #1;
  endtask

  function automatic logic [9:0] width_for(input logic [3:0] sel);
    case (sel)
      4'b0100: width_for = 10'd34;
      4'b0110: width_for = 10'd68;
      4'b0101: width_for = 10'd50;
      4'b0111: width_for = 10'd100;
      4'b1000: width_for = 10'd92;
      default: width_for = 10'd0;
    endcase
  endfunction

  task automatic check_issue(input string tag, input int unsigned k);
`ifndef OBSTACLE_LFSR_EN
    check_eq({tag, "_sel"}, obstacle_sel, rot_sel[k % 5]);
`endif
    check_eq({tag, "_width"}, final_width, width_for(obstacle_sel));
  endtask

  task automatic request(output logic seen);
    int n;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    seen = obs_valid;
    n = 1;
    while (!seen && n < 12) begin
      tick();
      n++;
      seen = obs_valid;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic        b;
    logic [3:0]  fz_sel;
    logic [9:0]  fz_w;
    logic        fz_bird;
    int unsigned k, nvalid, first_at;
`ifdef OBSTACLE_LFSR_EN
    int unsigned timeouts, triples;
    logic [4:0]  mask;
    logic [3:0]  p1, p2;
`endif

    #1 rst = 1'b1;
    #2;
    check_eq("rst_sel", obstacle_sel, 4'b0111);
    check_eq("rst_width", final_width, 100);
    check_eq("rst_bird", bird_frame, 1);
    check_eq("rst_valid", obs_valid, 0);
    check_eq("rst_pend", req_pending, 0);
    tick();
    rst = 1'b0;

    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check_eq("idle_valid", obs_valid, 0);
    check_eq("idle_sel", obstacle_sel, 4'b0111);
    check_eq("idle_bird", bird_frame, 1);

    gamestate = 2'b01;
    tick();
    k = 0;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check_eq("first_valid", obs_valid, 1);
    check_issue("first", k);
    k++;
    check_eq("first_pend", req_pending, 0);
    b = bird_frame;
    tick();
    check_eq("pulse_len", obs_valid, 0);
    check_eq("bird_toggle", bird_frame, !b);

    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check_eq("gap_pend", req_pending, 1);
    tick();
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check_eq("gap_hold_valid", obs_valid, 0);
    check_eq("gap_collapse_pend", req_pending, 1);
    nvalid = 0;
    first_at = 0;
    for (int e = 5; e <= 12; e++) begin
      tick();
      if (obs_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          first_at = e;
          check_issue("gap_issue", k);
        end
      end
    end
    k++;
    check_eq("gap_latency", first_at, 9);
    check_eq("gap_count", nvalid, 1);

    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check_eq("pre_freeze_pend", req_pending, 1);
    fz_sel  = obstacle_sel;
    fz_w    = final_width;
    fz_bird = bird_frame;
    gamestate = 2'b11;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      spawn_req = i[0];
      tick();
      if (obs_valid) nvalid++;
    end
    spawn_req = 1'b0;
    check_eq("frz_valid", nvalid, 0);
    check_eq("frz_sel", obstacle_sel, fz_sel);
    check_eq("frz_width", final_width, fz_w);
    check_eq("frz_bird", bird_frame, fz_bird);
    check_eq("frz_pend", req_pending, 1);

    gamestate = 2'b01;
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (obs_valid) begin
        nvalid++;
        check_issue("resume", k);
      end
    end
    k++;
    check_eq("resume_count", nvalid, 1);
    check_eq("resume_pend", req_pending, 0);

    for (int j = 0; j < 8; j++) begin
      request(seen);
      check_eq("rot_seen", seen, 1);
      check_issue("rot", k);
      k++;
    end

    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check_eq("pre_rst_pend", req_pending, 1);
    #3 rst = 1'b1;
    #1;
    check_eq("mid_rst_sel", obstacle_sel, 4'b0111);
    check_eq("mid_rst_width", final_width, 100);
    check_eq("mid_rst_bird", bird_frame, 1);
    check_eq("mid_rst_valid", obs_valid, 0);
    check_eq("mid_rst_pend", req_pending, 0);
    tick();
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_valid) nvalid++;
    end
    check_eq("rst_drop_req", nvalid, 0);
    k = 0;
    request(seen);
    check_eq("post_rst_seen", seen, 1);
    check_issue("post_rst", k);
    k++;

    gamestate = 2'b10;
    tick();
    b = bird_frame;
    nvalid = 0;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    if (obs_valid) nvalid++;
    tick();
    if (obs_valid) nvalid++;
    check_eq("gs10_valid", nvalid, 0);
    check_eq("gs10_bird", bird_frame, b);
    check_eq("gs10_pend", req_pending, 0);

    gamestate = 2'b01;
    tick();
    b = bird_frame0;
    spawn_req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("b2b_valid", obs_valid0, 1);
`ifndef OBSTACLE_LFSR_EN
      check_eq("b2b_sel", obstacle_sel0, (i == 1) ? 4'b0111 : 4'b0101);
`endif
      check_eq("b2b_width", final_width0, width_for(obstacle_sel0));
    end
    spawn_req0 = 1'b0;
    check_eq("b2b_bird", bird_frame0, !b);
    tick();
    check_eq("b2b_stop", obs_valid0, 0);
    check_eq("b2b_pend", req_pending0, 0);

`ifdef OBSTACLE_LFSR_EN
    timeouts = 0;
    triples  = 0;
    mask     = '0;
    p1       = '0;
    p2       = '0;
    for (int n = 0; n < 1000; n++) begin
      request(seen);
      if (!seen) begin
        timeouts++;
      end else begin
        if (n >= 2 && obstacle_sel == p1 && p1 == p2) triples++;
        p2 = p1;
        p1 = obstacle_sel;
        case (obstacle_sel)
          4'b0100: mask[0] = 1'b1;
          4'b0110: mask[1] = 1'b1;
          4'b0101: mask[2] = 1'b1;
          4'b0111: mask[3] = 1'b1;
          4'b1000: mask[4] = 1'b1;
          default: ;
        endcase
      end
    end
    check_eq("lfsr_timeouts", timeouts, 0);
    check_eq("lfsr_triples", triples, 0);
    check_eq("lfsr_all_types", mask, 5'b11111);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
